// File: rtl/inout_sram_master_if.sv
// Command, write-stream, read-stream and SRAM pin bundle for inout_sram_master.
// master = the burst engine, slave = the datapath/SRAM side.
interface inout_sram_master_if #(
  parameter int unsigned ADDR_W = 18,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned LEN_W  = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [LEN_W-1:0]  cmd_len;

  logic              wr_valid;
  logic              wr_ready;
  logic [DATA_W-1:0] wr_data;

  logic              rd_valid;
  logic              rd_ready;
  logic [DATA_W-1:0] rd_data;

  logic              busy;
  logic              done;
  logic              err;

  logic              SRAM_CS;
  logic              SRAM_OE;
  logic              SRAM_WEB;
  logic [ADDR_W-1:0] SRAM_A;
  logic [DATA_W-1:0] SRAM_DI;
  logic [DATA_W-1:0] SRAM_DO;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len,
    input  wr_valid, wr_data,
    input  rd_ready,
    input  SRAM_DO,
    output cmd_ready, wr_ready, rd_valid, rd_data,
    output busy, done, err,
    output SRAM_CS, SRAM_OE, SRAM_WEB, SRAM_A, SRAM_DI
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_len,
    output wr_valid, wr_data,
    output rd_ready,
    output SRAM_DO,
    input  cmd_ready, wr_ready, rd_valid, rd_data,
    input  busy, done, err,
    input  SRAM_CS, SRAM_OE, SRAM_WEB, SRAM_A, SRAM_DI
  );
endinterface

// File: rtl/inout_sram_master.sv
// Burst engine for the InOut SRAM pins: write bursts from a stream, read bursts to a stream.
// Define INOUT_SRAM_BOUND_CHECK_EN to reject bursts that run past MAX_ADDR (err pulse).
module inout_sram_master #(
  parameter int unsigned       ADDR_W   = 18,
  parameter int unsigned       DATA_W   = 16,
  parameter int unsigned       LEN_W    = 16,
  parameter logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(18'h2FFFF)
) (
  input  logic                CK,
  input  logic                RSTn,
  inout_sram_master_if.master bus
);

  localparam int unsigned SUM_W = ADDR_W + LEN_W + 1;

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  remain_q;
  logic              oe_q;
  logic              done_q;
  logic              err_q;

  logic [DATA_W-1:0] fifo_q [2];
  logic              wptr_q;
  logic              rptr_q;
  logic [1:0]        count_q;

  logic              wr_beat;
  logic              rd_issue;
  logic              pop;
  logic              last_beat;
  logic [2:0]        occ;
  logic [SUM_W-1:0]  end_sum;
  logic              over_range;
  logic              reject;

  assign wr_beat   = (state_q == WRITE) && bus.wr_valid;
  assign pop       = (count_q != 2'd0) && bus.rd_ready;
  assign last_beat = (remain_q == LEN_W'(1));

  // Buffered + in-flight beats after this cycle's pop; a new issue needs room for its reply.
  assign occ      = 3'(count_q) + 3'(oe_q) - 3'(pop);
  assign rd_issue = (state_q == READ) && (occ < 3'd2);

  assign end_sum    = SUM_W'(bus.cmd_addr) + SUM_W'(bus.cmd_len) - SUM_W'(1);
  assign over_range = (bus.cmd_len != '0) && (end_sum > SUM_W'(MAX_ADDR));

`ifdef INOUT_SRAM_BOUND_CHECK_EN
  assign reject = over_range;
`else
  logic unused_over_range;
  assign unused_over_range = over_range;
  assign reject = 1'b0;
`endif

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.wr_ready  = (state_q == WRITE);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.rd_valid  = (count_q != 2'd0);
  assign bus.rd_data   = fifo_q[rptr_q];

  // SRAM pins follow the accepted beat / issue in the same cycle; idle values otherwise.
  assign bus.SRAM_CS  = wr_beat || rd_issue;
  assign bus.SRAM_WEB = !wr_beat;
  assign bus.SRAM_OE  = oe_q;
  assign bus.SRAM_A   = (wr_beat || rd_issue) ? addr_q : '0;
  assign bus.SRAM_DI  = wr_beat ? bus.wr_data : '0;

  // Burst control FSM.
  always_ff @(posedge CK or negedge RSTn) begin
    if (!RSTn) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      remain_q <= '0;
      oe_q     <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      oe_q   <= rd_issue;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            addr_q   <= bus.cmd_addr;
            remain_q <= bus.cmd_len;
            if (reject) begin
              err_q <= 1'b1;
            end else if (bus.cmd_len == '0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= bus.cmd_write ? WRITE : READ;
            end
          end
        end
        WRITE: begin
          if (wr_beat) begin
            addr_q   <= addr_q + ADDR_W'(1);
            remain_q <= remain_q - LEN_W'(1);
            if (last_beat) begin
              state_q <= IDLE;
              done_q  <= 1'b1;
            end
          end
        end
        READ: begin
          if (rd_issue) begin
            addr_q   <= addr_q + ADDR_W'(1);
            remain_q <= remain_q - LEN_W'(1);
            if (last_beat) begin
              state_q <= DRAIN;
            end
          end
        end
        DRAIN: begin
          // Finish in the cycle of the final pop so done lands right after it.
          if (!oe_q && (count_q == 2'(pop))) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Two-entry read return FIFO; SRAM_DO is valid during the OE cycle.
  always_ff @(posedge CK or negedge RSTn) begin
    if (!RSTn) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wptr_q    <= 1'b0;
      rptr_q    <= 1'b0;
      count_q   <= 2'd0;
    end else begin
      if (oe_q) begin
        fifo_q[wptr_q] <= bus.SRAM_DO;
        wptr_q         <= !wptr_q;
      end
      if (pop) begin
        rptr_q <= !rptr_q;
      end
      count_q <= count_q + 2'(oe_q) - 2'(pop);
    end
  end

endmodule

// File: tb/tb_inout_sram_master.sv
// Directed self-checking bench for inout_sram_master with a one-cycle-latency SRAM model.
module tb_inout_sram_master;

  localparam int unsigned ADDR_W = 18;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned LEN_W  = 16;

  logic CK   = 1'b0;
  logic RSTn = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  inout_sram_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

  inout_sram_master #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .CK  (CK),
    .RSTn(RSTn),
    .bus (bus)
  );

  always #5 CK = ~CK;

  // SRAM model: write on the CS edge, read data presented during the following cycle.
  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];
  logic [DATA_W-1:0] do_q = '0;
  always @(posedge CK) begin
    if (bus.SRAM_CS && !bus.SRAM_WEB) mem[bus.SRAM_A] <= bus.SRAM_DI;
    if (bus.SRAM_CS &&  bus.SRAM_WEB) do_q <= mem[bus.SRAM_A];
  end
  assign bus.SRAM_DO = do_q;

  // {cmd_ready, wr_ready, rd_valid, busy, done, err, CS, OE, WEB}
  function automatic logic [8:0] flags();
    return {bus.cmd_ready, bus.wr_ready, bus.rd_valid, bus.busy, bus.done,
            bus.err, bus.SRAM_CS, bus.SRAM_OE, bus.SRAM_WEB};
  endfunction

  task automatic idle_inputs();
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    bus.wr_valid  = 1'b0;
    bus.wr_data   = '0;
    bus.rd_ready  = 1'b0;
  endtask

  task automatic write_burst(input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] base,
                             input int len);
    @(negedge CK);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = addr; bus.cmd_len = LEN_W'(len);
    for (int i = 0; i < len; i++) begin
      @(negedge CK);
      bus.cmd_valid = 1'b0; bus.wr_valid = 1'b1; bus.wr_data = base + DATA_W'(i);
    end
    @(negedge CK);
    bus.wr_valid = 1'b0;
    @(negedge CK);
  endtask

  task automatic test_reset();
    idle_inputs();
    RSTn = 1'b0;
    repeat (3) @(negedge CK);
    #1;
    n_tests++;
    if (flags() !== 9'b100000001) begin
      n_fail++; $display("FAIL reset_flags_during: got %b expected %b", flags(), 9'b100000001);
    end
    n_tests++;
    if (bus.SRAM_A !== '0 || bus.SRAM_DI !== '0 || bus.rd_data !== '0) begin
      n_fail++; $display("FAIL reset_bus_during: A=%h DI=%h rd_data=%h expected 0", bus.SRAM_A, bus.SRAM_DI, bus.rd_data);
    end
    RSTn = 1'b1;
    @(negedge CK); #1;
    n_tests++;
    if (flags() !== 9'b100000001) begin
      n_fail++; $display("FAIL reset_flags_after: got %b expected %b", flags(), 9'b100000001);
    end
  endtask

  task automatic test_write();
    logic [ADDR_W-1:0] exp_a;
    @(negedge CK);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 18'h07FFE; bus.cmd_len = 16'd4;
    #1;
    n_tests++;
    if (bus.cmd_ready !== 1'b1 || bus.SRAM_CS !== 1'b0) begin
      n_fail++; $display("FAIL write_cmd: cmd_ready=%b CS=%b expected 1/0", bus.cmd_ready, bus.SRAM_CS);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge CK);
      bus.cmd_valid = 1'b0; bus.wr_valid = 1'b1; bus.wr_data = 16'hA000 + 16'(i);
      exp_a = 18'h07FFE + 18'(i);
      #1;
      n_tests++;
      if (flags() !== 9'b010100100 || bus.SRAM_A !== exp_a || bus.SRAM_DI !== 16'hA000 + 16'(i)) begin
        n_fail++; $display("FAIL write_beat%0d: flags=%b A=%h DI=%h expected %b %h %h",
                           i, flags(), bus.SRAM_A, bus.SRAM_DI, 9'b010100100, exp_a, 16'hA000 + 16'(i));
      end
    end
    @(negedge CK);
    bus.wr_valid = 1'b0;
    #1;
    n_tests++;
    if (flags() !== 9'b100010001) begin
      n_fail++; $display("FAIL write_done: got %b expected %b", flags(), 9'b100010001);
    end
    @(negedge CK); #1;
    n_tests++;
    if (flags() !== 9'b100000001) begin
      n_fail++; $display("FAIL write_done_clear: got %b expected %b", flags(), 9'b100000001);
    end
    for (int i = 0; i < 4; i++) begin
      exp_a = 18'h07FFE + 18'(i);
      n_tests++;
      if (mem[exp_a] !== 16'hA000 + 16'(i)) begin
        n_fail++; $display("FAIL write_mem%0d: got %h expected %h", i, mem[exp_a], 16'hA000 + 16'(i));
      end
    end
  endtask

  task automatic test_read_stream();
    logic              e_cs, e_oe, e_valid, e_busy, e_done;
    logic [ADDR_W-1:0] e_a;
    logic [8:0]        e_flags;
    @(negedge CK);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 18'h07FFE; bus.cmd_len = 16'd4;
    for (int k = 1; k <= 7; k++) begin
      @(negedge CK);
      bus.cmd_valid = 1'b0; bus.rd_ready = 1'b1;
      e_cs    = (k <= 4);
      e_a     = e_cs ? 18'h07FFE + 18'(k - 1) : '0;
      e_oe    = (k >= 2 && k <= 5);
      e_valid = (k >= 3 && k <= 6);
      e_busy  = (k <= 6);
      e_done  = (k == 7);
      e_flags = {!e_busy, 1'b0, e_valid, e_busy, e_done, 1'b0, e_cs, e_oe, 1'b1};
      #1;
      n_tests++;
      if (flags() !== e_flags || bus.SRAM_A !== e_a) begin
        n_fail++; $display("FAIL read_stream_c%0d: flags=%b A=%h expected %b %h", k, flags(), bus.SRAM_A, e_flags, e_a);
      end
      if (e_valid) begin
        n_tests++;
        if (bus.rd_data !== 16'hA000 + 16'(k - 3)) begin
          n_fail++; $display("FAIL read_stream_data%0d: got %h expected %h", k, bus.rd_data, 16'hA000 + 16'(k - 3));
        end
      end
    end
    bus.rd_ready = 1'b0;
  endtask

  task automatic test_read_backpressure();
    logic pat [4];
    logic prev_issue;
    logic seen_done;
    int   issued, popped, outst;
    pat[0] = 1'b1; pat[1] = 1'b0; pat[2] = 1'b0; pat[3] = 1'b1;
    write_burst(18'h00100, 16'hB000, 8);
    @(negedge CK);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 18'h00100; bus.cmd_len = 16'd8;
    issued = 0; popped = 0; prev_issue = 1'b0; seen_done = 1'b0;
    for (int k = 1; k <= 80 && !seen_done; k++) begin
      @(negedge CK);
      bus.cmd_valid = 1'b0;
      bus.rd_ready  = pat[(k - 1) % 4];
      #1;
      outst = issued - popped;
      n_tests++;
      if (bus.SRAM_OE !== prev_issue) begin
        n_fail++; $display("FAIL bp_oe_c%0d: got %b expected %b", k, bus.SRAM_OE, prev_issue);
      end
      n_tests++;
      if (outst > 2) begin
        n_fail++; $display("FAIL bp_outstanding_c%0d: got %0d expected <=2", k, outst);
      end
      if (bus.rd_valid && bus.rd_ready && outst == 2 && issued < 8) begin
        n_tests++;
        if (bus.SRAM_CS !== 1'b1) begin
          n_fail++; $display("FAIL bp_resume_c%0d: CS=%b expected 1", k, bus.SRAM_CS);
        end
      end
      if (bus.SRAM_CS) begin
        n_tests++;
        if (bus.SRAM_WEB !== 1'b1 || bus.SRAM_A !== 18'h00100 + 18'(issued)) begin
          n_fail++; $display("FAIL bp_issue%0d: WEB=%b A=%h expected 1 %h", issued, bus.SRAM_WEB, bus.SRAM_A, 18'h00100 + 18'(issued));
        end
        issued++;
      end
      if (bus.rd_valid && bus.rd_ready) begin
        n_tests++;
        if (bus.rd_data !== 16'hB000 + 16'(popped)) begin
          n_fail++; $display("FAIL bp_data%0d: got %h expected %h", popped, bus.rd_data, 16'hB000 + 16'(popped));
        end
        popped++;
      end
      if (bus.done) begin
        seen_done = 1'b1;
        n_tests++;
        if (issued != 8 || popped != 8) begin
          n_fail++; $display("FAIL bp_counts: issued=%0d popped=%0d expected 8/8", issued, popped);
        end
      end
      prev_issue = bus.SRAM_CS;
    end
    n_tests++;
    if (!seen_done) begin
      n_fail++; $display("FAIL bp_timeout: done=%b expected 1 within 80 cycles", seen_done);
    end
    bus.rd_ready = 1'b0;
  endtask

  task automatic test_empty_cmd();
    @(negedge CK);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 18'h00123; bus.cmd_len = 16'd0;
    #1;
    n_tests++;
    if (bus.cmd_ready !== 1'b1 || bus.SRAM_CS !== 1'b0) begin
      n_fail++; $display("FAIL empty_cmd: cmd_ready=%b CS=%b expected 1/0", bus.cmd_ready, bus.SRAM_CS);
    end
    @(negedge CK);
    bus.cmd_valid = 1'b0;
    #1;
    n_tests++;
    if (flags() !== 9'b100010001) begin
      n_fail++; $display("FAIL empty_done: got %b expected %b", flags(), 9'b100010001);
    end
    @(negedge CK); #1;
    n_tests++;
    if (flags() !== 9'b100000001) begin
      n_fail++; $display("FAIL empty_after: got %b expected %b", flags(), 9'b100000001);
    end
  endtask

`ifdef INOUT_SRAM_BOUND_CHECK_EN
  task automatic test_bound_check();
    @(negedge CK);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 18'h2FFFE; bus.cmd_len = 16'd3;
    #1;
    n_tests++;
    if (bus.SRAM_CS !== 1'b0) begin
      n_fail++; $display("FAIL bound_cmd_cs: got %b expected 0", bus.SRAM_CS);
    end
    @(negedge CK);
    bus.cmd_valid = 1'b0; bus.wr_valid = 1'b1; bus.wr_data = 16'hDEAD;
    #1;
    n_tests++;
    if (flags() !== 9'b100001001) begin
      n_fail++; $display("FAIL bound_err: got %b expected %b", flags(), 9'b100001001);
    end
    @(negedge CK);
    bus.wr_valid = 1'b0;
    #1;
    n_tests++;
    if (flags() !== 9'b100000001) begin
      n_fail++; $display("FAIL bound_err_clear: got %b expected %b", flags(), 9'b100000001);
    end
    @(negedge CK);
    bus.cmd_valid = 1'b1; bus.cmd_addr = 18'h2FFFE; bus.cmd_len = 16'd2;
    for (int i = 0; i < 2; i++) begin
      @(negedge CK);
      bus.cmd_valid = 1'b0; bus.wr_valid = 1'b1; bus.wr_data = 16'hC000 + 16'(i);
      #1;
      n_tests++;
      if (bus.SRAM_CS !== 1'b1 || bus.SRAM_A !== 18'h2FFFE + 18'(i)) begin
        n_fail++; $display("FAIL bound_ok_beat%0d: CS=%b A=%h expected 1 %h", i, bus.SRAM_CS, bus.SRAM_A, 18'h2FFFE + 18'(i));
      end
    end
    @(negedge CK);
    bus.wr_valid = 1'b0;
    #1;
    n_tests++;
    if (flags() !== 9'b100010001) begin
      n_fail++; $display("FAIL bound_ok_done: got %b expected %b", flags(), 9'b100010001);
    end
  endtask
`else
  task automatic test_err_tied();
    @(negedge CK);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b1; bus.cmd_addr = 18'h00200; bus.cmd_len = 16'd1;
    @(negedge CK);
    bus.cmd_valid = 1'b0; bus.wr_valid = 1'b1; bus.wr_data = 16'h1234;
    #1;
    n_tests++;
    if (bus.err !== 1'b0 || bus.SRAM_CS !== 1'b1) begin
      n_fail++; $display("FAIL err_tied_beat: err=%b CS=%b expected 0/1", bus.err, bus.SRAM_CS);
    end
    @(negedge CK);
    bus.wr_valid = 1'b0;
    #1;
    n_tests++;
    if (flags() !== 9'b100010001) begin
      n_fail++; $display("FAIL err_tied_done: got %b expected %b", flags(), 9'b100010001);
    end
  endtask
`endif

  task automatic test_reset_mid_burst();
    int  popped;
    logic seen_done;
    @(negedge CK);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 18'h00100; bus.cmd_len = 16'd8;
    popped = 0;
    for (int k = 0; k < 30 && popped < 3; k++) begin
      @(negedge CK);
      bus.cmd_valid = 1'b0; bus.rd_ready = 1'b1;
      #1;
      if (bus.rd_valid) begin
        n_tests++;
        if (bus.rd_data !== 16'hB000 + 16'(popped)) begin
          n_fail++; $display("FAIL rstmid_data%0d: got %h expected %h", popped, bus.rd_data, 16'hB000 + 16'(popped));
        end
        popped++;
      end
    end
    @(negedge CK);
    RSTn = 1'b0;
    #1;
    n_tests++;
    if (flags() !== 9'b100000001 || bus.SRAM_A !== '0 || bus.SRAM_DI !== '0 || bus.rd_data !== '0) begin
      n_fail++; $display("FAIL rstmid_outputs: flags=%b A=%h DI=%h rd_data=%h expected %b 0 0 0",
                         flags(), bus.SRAM_A, bus.SRAM_DI, bus.rd_data, 9'b100000001);
    end
    @(negedge CK);
    RSTn = 1'b1;
    @(negedge CK);
    bus.cmd_valid = 1'b1; bus.cmd_addr = 18'h00100; bus.cmd_len = 16'd2;
    popped = 0; seen_done = 1'b0;
    for (int k = 0; k < 20 && !seen_done; k++) begin
      @(negedge CK);
      bus.cmd_valid = 1'b0;
      #1;
      if (bus.rd_valid) begin
        n_tests++;
        if (bus.rd_data !== 16'hB000 + 16'(popped)) begin
          n_fail++; $display("FAIL rstmid_new_data%0d: got %h expected %h", popped, bus.rd_data, 16'hB000 + 16'(popped));
        end
        popped++;
      end
      if (bus.done) seen_done = 1'b1;
    end
    n_tests++;
    if (!seen_done || popped != 2) begin
      n_fail++; $display("FAIL rstmid_new_done: done=%b beats=%0d expected 1/2", seen_done, popped);
    end
    bus.rd_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_stream();
    test_empty_cmd();
    test_read_backpressure();
`ifdef INOUT_SRAM_BOUND_CHECK_EN
    test_bound_check();
`else
    test_err_tied();
`endif
    test_reset_mid_burst();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
